ntt_scheduler: RTL and testbench
================================

# ntt_scheduler

Control stage directly upstream of the butterfly unit. It sequences a full 256-point Kyber NTT (Cooley-Tukey) or INTT (Gentleman-Sande) over q = 3329, one butterfly issue per cycle. For each butterfly it generates:
- coefficient-RAM read addresses;
- the zeta ROM index;
- the butterfly `operation` code and issue valid;
- delay-matched write-back addresses.

It also inserts drain bubbles at layer boundaries so no read overtakes a pending write.

## Interface
Parameters:
- `RD_LATENCY`, 1: read latency of coefficient RAM and zeta ROM (cycles, ≥1).
- `BF_LATENCY`, 7: butterfly unit latency, `valid_in` to `valid_out`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transform; honoured only in IDLE.
- `mode`  in  1  0 = NTT, 1 = INTT; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the last write-back has been issued.
- `rd_en`  out  1  read strobe to coefficient RAM and zeta ROM.
- `rd_addr_a`, `rd_addr_b`  out  8 each  coefficient read addresses.
- `zeta_idx`  out  7  zeta ROM index, presented with `rd_en`.
- `bf_valid`  out  1  butterfly `valid_in`; this is `rd_en` delayed by `RD_LATENCY`.
- `bf_operation`  out  2  2'b00 for NTT, 2'b01 for INTT, aligned with `bf_valid`.
- `wr_en`  out  1  write strobe; this is `bf_valid` delayed by `BF_LATENCY`.
- `wr_addr_a`, `wr_addr_b`  out  8 each  write addresses aligned with `wr_en`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on `start`.
  - ISSUE → DRAIN after issue 127 of a layer.
  - DRAIN → ISSUE (next layer) after D = `RD_LATENCY` + `BF_LATENCY` cycles, or DRAIN → DONE after layer 6.
  - DONE → IDLE after one cycle.
- Counters: `layer` runs 0..6; `bf` runs 0..127 within the layer.
- Butterfly span: `len` = 128>>layer for NTT, 2<<layer for INTT.
- Index arithmetic (shifts and masks only, no dividers):
  - `g` = bf / len.
  - `rd_addr_a` = g·2·len + (bf mod len).
  - `rd_addr_b` = `rd_addr_a` + len.
- Zeta index:
  - NTT: `zeta_idx` = (1<<layer) + g, covering 1..127 in increasing order.
  - INTT: `zeta_idx` = (128>>layer) − 1 − g, covering 127..1 in decreasing order.
- `mode` is latched at `start` and held for the whole transform; changing `mode` while busy has no effect.
- `start` while busy, or in DONE, is ignored.
- Address, op and valid delay lines are shift registers. `wr_addr_*` are the issued `rd_addr_*` delayed by D.
- Reset value of every output is 0. Reset mid-transform:
  - clears the FSM, counters and all delay lines;
  - `wr_en` and `bf_valid` are low from reset assertion on, with no write-back of in-flight entries.
- INTT final scaling by n⁻¹ is not performed here.

## Timing
- Let c1 be the cycle after the edge that samples `start`. `busy` and `rd_en` first go high in c1.
- Layer L issues in cycles c1 + L·(128+D) through c1 + L·(128+D) + 127, contiguous, `rd_en` high throughout.
- D drain cycles follow each layer with `rd_en` low. The last `wr_en` of a layer lands in the final drain cycle, so the next layer's first read comes one cycle after that write.
- `done` pulses in cycle c1 + 7·(128+D); `busy` is low from the following cycle.
- Defaults (D = 8): 896 issues, `done` at c1 + 952.
- A new `start` is accepted in the cycle after `done`, i.e. back-to-back transforms are supported.

## Configuration
- `NTT_SCHED_CYCCNT_EN` defined: adds output `cycle_count` (16 bits).
  - Cleared to 0 when `start` is accepted.
  - Increments every cycle `busy` is high.
  - Holds its value after `done`; reset value 0.
  - Default run ends at 953.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: assert `reset` = 0 with `start` = 1 → all outputs 0 and no `rd_en` while reset is low; after release, no activity until a `start` pulse.
- NTT addressing: `mode` = 0, `start`.
  - c1: a=0, b=128, zeta=1.
  - c128: a=127, b=255, zeta=1.
  - c137: a=0, b=64, zeta=2.
  - c201: a=128, b=192, zeta=3.
  - Layer 6 first/third/last issue: (0,2,64), (4,6,65), (253,255,127).
- INTT addressing: `mode` = 1.
  - c1: a=0, b=2, zeta=127, `bf_operation` = 01.
  - c3: a=4, b=6, zeta=126.
  - Layer 6 first issue: a=0, b=128, zeta=1.
- Pipeline alignment:
  - `bf_valid` lags `rd_en` by 1 cycle; `wr_en` lags `rd_en` by 8 with the same a/b addresses.
  - 896 `wr_en` pulses in total; `done` at c1 + 952.
  - No `rd_en` overlaps a prior layer's pending `wr_en`.
- Ignored start: pulse `start` with `mode` = 1 at c300 of an NTT run → address sequence and `bf_operation` unchanged; `done` still at c1 + 952.
- Reset mid-run: assert reset at c450 (layer 3) → `wr_en`, `bf_valid` and `busy` are 0 immediately with no further writes. A fresh `start` then reproduces the test-2 sequence from c1.

Source files
------------

// File: rtl/ntt_scheduler_if.sv
// Scheduler <-> control/datapath bundle for the Kyber NTT/INTT sequencer.
// NTT_SCHED_CYCCNT_EN adds the 16-bit cycle_count observation port.
interface ntt_sched_if;
  logic       start;
  logic       mode;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [6:0] zeta_idx;
  logic       bf_valid;
  logic [1:0] bf_operation;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;
`ifdef NTT_SCHED_CYCCNT_EN
  logic [15:0] cycle_count;
`endif

  modport master (
    input  start, mode,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx,
           bf_valid, bf_operation, wr_en, wr_addr_a, wr_addr_b
`ifdef NTT_SCHED_CYCCNT_EN
    , output cycle_count
`endif
  );

  modport slave (
    output start, mode,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx,
           bf_valid, bf_operation, wr_en, wr_addr_a, wr_addr_b
`ifdef NTT_SCHED_CYCCNT_EN
    , input cycle_count
`endif
  );
endinterface

// File: rtl/ntt_scheduler.sv
// Issue sequencer for a 256-point Kyber NTT/INTT: one butterfly per cycle, layer drains.
// Optional NTT_SCHED_CYCCNT_EN adds a busy-cycle counter on cycle_count.
module ntt_scheduler #(
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = 7
) (
  input  logic         clk,
  input  logic         reset,
  ntt_sched_if.master  bus
);
  localparam int D  = RD_LATENCY + BF_LATENCY;
  localparam int DW = (D > 2) ? $clog2(D) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    layer_q, layer_d;
  logic [6:0]    bf_q, bf_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          mode_q, mode_d;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bf_d    = bf_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_ISSUE;
        mode_d  = bus.mode;
        layer_d = 3'd0;
        bf_d    = 7'd0;
        drain_d = '0;
      end
      S_ISSUE: begin
        bf_d = bf_q + 7'd1;
        if (bf_q == 7'd127) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        // Leave only once the last write of the layer is on the bus this cycle.
        if (drain_q == DW'(D - 1)) begin
          drain_d = '0;
          if (layer_q == 3'd6) state_d = S_DONE;
          else begin
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      layer_q <= 3'd0;
      bf_q    <= 7'd0;
      drain_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      bf_q    <= bf_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
    end
  end

  // len = 1<<lg; g = bf>>lg; a = g*2*len + (bf & (len-1)).
  logic       issuing;
  logic [2:0] lg;
  logic [3:0] lg2;
  logic [7:0] len, off, a_raw, b_raw;
  logic [6:0] g, zeta_raw;

  always_comb begin
    issuing  = (state_q == S_ISSUE);
    lg       = mode_q ? (layer_q + 3'd1) : (3'd7 - layer_q);
    lg2      = {1'b0, lg} + 4'd1;
    len      = 8'd1 << lg;
    g        = bf_q >> lg;
    off      = {1'b0, bf_q} & (len - 8'd1);
    a_raw    = ({1'b0, g} << lg2) | off;
    b_raw    = a_raw + len;
    zeta_raw = mode_q ? ((7'd127 >> layer_q) - g) : ((7'd1 << layer_q) + g);
  end

  assign bus.rd_en     = issuing;
  assign bus.rd_addr_a = issuing ? a_raw : 8'd0;
  assign bus.rd_addr_b = issuing ? b_raw : 8'd0;
  assign bus.zeta_idx  = issuing ? zeta_raw : 7'd0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

  logic [D:1]       vld_q;
  logic [D:0]       vld_pipe;
  logic [D:1][15:0] adr_q;

  assign vld_pipe = {vld_q, bus.rd_en};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      adr_q <= '0;
    end else begin
      vld_q    <= vld_pipe[D-1:0];
      adr_q[1] <= {bus.rd_addr_a, bus.rd_addr_b};
      for (int i = 2; i <= D; i++) adr_q[i] <= adr_q[i-1];
    end
  end

  assign bus.bf_valid     = vld_pipe[RD_LATENCY];
  assign bus.bf_operation = bus.bf_valid ? {1'b0, mode_q} : 2'b00;
  assign bus.wr_en        = vld_pipe[D];
  assign bus.wr_addr_a    = adr_q[D][15:8];
  assign bus.wr_addr_b    = adr_q[D][7:0];

`ifdef NTT_SCHED_CYCCNT_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              cyc_q <= 16'd0;
    else if (state_q == S_IDLE && bus.start) cyc_q <= 16'd0;
    else if (bus.busy)                       cyc_q <= cyc_q + 16'd1;
  end
  assign bus.cycle_count = cyc_q;
`endif
endmodule

// File: tb/tb_ntt_scheduler.sv
// Scoreboard bench for ntt_scheduler: reference loop model plus hand-computed spot vectors.
module tb_ntt_scheduler;
  logic clk = 1'b0;
  logic reset;
  ntt_sched_if bus();

  ntt_scheduler #(.RD_LATENCY(1), .BF_LATENCY(7)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [7:0] a; logic [7:0] b; logic [6:0] z;} ev_t;
  ev_t  exp_rd[$], exp_wr[$], spot[$];
  int   exp_bv[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, wr_cnt = 0, exp_done = -1;
  bit   done_seen = 1'b0, busy_d = 1'b0;
  logic [1:0] exp_op = 2'b00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: cyc counts from 1 at the first busy cycle (c1).
  always @(negedge clk) begin : mon
    ev_t e;
    int  c;
    if (bus.busy && !busy_d) begin cyc = 1; wr_cnt = 0; end
    else cyc++;
    busy_d = bus.busy;
    if (bus.rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 64'(bus.rd_en), 64'd0);
      else begin
        e = exp_rd.pop_front();
        chk("rd_issue", {cyc, bus.rd_addr_a, bus.rd_addr_b, bus.zeta_idx}, {e.cyc, e.a, e.b, e.z});
      end
    end
    if (bus.bf_valid) begin
      if (exp_bv.size() == 0) chk("bf_unexpected", 64'(bus.bf_valid), 64'd0);
      else begin
        c = exp_bv.pop_front();
        chk("bf_valid_op", {cyc, bus.bf_operation}, {c, exp_op});
      end
    end
    if (bus.wr_en) begin
      wr_cnt++;
      if (exp_wr.size() == 0) chk("wr_unexpected", 64'(bus.wr_en), 64'd0);
      else begin
        e = exp_wr.pop_front();
        chk("wr_back", {cyc, bus.wr_addr_a, bus.wr_addr_b}, {e.cyc, e.a, e.b});
      end
    end
    if (spot.size() != 0 && spot[0].cyc == cyc) begin
      e = spot.pop_front();
      chk("spot", {bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.zeta_idx}, {1'b1, e.a, e.b, e.z});
    end
    if (bus.done) begin
      done_seen = 1'b1;
      if (exp_done < 0) chk("done_unexpected", 64'(bus.done), 64'd0);
      else begin
        chk("done_cycle", cyc, exp_done);
        chk("wr_total", wr_cnt, 896);
        exp_done = -1;
      end
    end
  end

  // Kyber reference loop nest; timing c = L*(128+8) + n + 1.
  task automatic push_model(input logic m);
    int len, k, n;
    k   = m ? 127 : 1;
    len = m ? 2 : 128;
    for (int L = 0; L < 7; L++) begin
      n = 0;
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ev_t e;
          e.cyc = L * 136 + n + 1; e.a = 8'(j); e.b = 8'(j + len); e.z = 7'(k);
          exp_rd.push_back(e);
          exp_bv.push_back(e.cyc + 1);
          e.cyc = e.cyc + 8; e.z = 7'd0;
          exp_wr.push_back(e);
          n++;
        end
        k = m ? k - 1 : k + 1;
      end
      len = m ? len * 2 : len / 2;
    end
    exp_op   = {1'b0, m};
    exp_done = 953;
  endtask

  task automatic add_spot(input int c, input int a, input int b, input int z);
    ev_t e;
    e.cyc = c; e.a = 8'(a); e.b = 8'(b); e.z = 7'(z);
    spot.push_back(e);
  endtask

  task automatic spots_ntt();
    add_spot(1, 0, 128, 1);   add_spot(128, 127, 255, 1);
    add_spot(137, 0, 64, 2);  add_spot(201, 128, 192, 3);
    add_spot(817, 0, 2, 64);  add_spot(819, 4, 6, 65);
    add_spot(944, 253, 255, 127);
  endtask

  task automatic spots_intt();
    add_spot(1, 0, 2, 127); add_spot(3, 4, 6, 126); add_spot(817, 0, 128, 1);
  endtask

  // Called just after a rising edge; start is sampled by the next edge.
  task automatic start_now(input logic m);
    done_seen = 1'b0;
    bus.start = 1'b1; bus.mode = m;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mode = ~m;
    chk("busy_c1", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 2000 && cyc != n; i++) @(posedge clk);
    #1;
    chk("reach_cycle", cyc, n - 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1200 && !done_seen; i++) @(posedge clk);
    #1;
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("queues_empty", exp_rd.size() + exp_wr.size() + exp_bv.size() + spot.size(), 0);
  endtask

  task automatic flush();
    exp_rd.delete(); exp_wr.delete(); exp_bv.delete(); spot.delete();
    exp_done = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; bus.start = 1'b1; bus.mode = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("reset_outputs", {bus.busy, bus.done, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
                            bus.zeta_idx, bus.bf_valid, bus.bf_operation, bus.wr_en,
                            bus.wr_addr_a, bus.wr_addr_b}, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1; bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("idle_after_reset", {bus.busy, bus.rd_en}, 64'd0);

    // NTT with an ignored INTT start at c300.
    @(posedge clk); #1;
    push_model(1'b0); spots_ntt(); start_now(1'b0);
    wait_cyc(299);
    bus.start = 1'b1; bus.mode = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mode = 1'b0;
    chk("busy_ignored_start", 64'(bus.busy), 64'd1);
    wait_done();

    // Back-to-back INTT, started in the cycle right after done.
    push_model(1'b1); spots_intt(); start_now(1'b1);
    wait_done();

    // NTT aborted by reset at c450, then rerun from scratch.
    push_model(1'b0); start_now(1'b0);
    wait_cyc(449);
    reset = 1'b0;
    #1 chk("reset_mid_outputs", {bus.busy, bus.bf_valid, bus.wr_en, bus.rd_en}, 64'd0);
    flush();
    repeat (3) @(posedge clk);
    #1 chk("reset_hold_outputs", {bus.busy, bus.bf_valid, bus.wr_en, bus.rd_en}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    push_model(1'b0); spots_ntt(); start_now(1'b0);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
